// File: rtl/status_pio_pkg.sv
// Shared constants for the status PIO: Avalon register map, edge-mode encodings, counter width.
package status_pio_pkg;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_EDGE  = 2'd2;
    localparam logic [1:0] ADDR_COUNT = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int COUNT_W = 16;

endpackage

// File: rtl/status_pio_sync.sv
// Purpose: WIDTH-bit multi-flop synchroniser for asynchronous status inputs.
// Latency: STAGES clk edges from d to q.
// Backpressure: none, free-running every cycle.
module status_pio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/status_pio_capture.sv
// Purpose: Avalon-MM status PIO with edge capture (W1C), event counter and, with STATUS_PIO_IRQ_EN, maskable irq.
// Latency: readdata 1 cycle after address; input to DATA SYNC_STAGES cycles, to EDGE one more, irq one after EDGE.
// Backpressure: none, zero wait states; read strobe is not required.
module status_pio_capture
    import status_pio_pkg::*;
#(
    parameter int               WIDTH          = 8,
    parameter int               SYNC_STAGES    = 2,
    parameter int               EDGE_MODE      = 0,
    parameter logic [WIDTH-1:0] IRQ_RESET_MASK = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int ARM_W = $clog2(SYNC_STAGES + 2);

    logic [WIDTH-1:0]   sync_q;
    logic [WIDTH-1:0]   prev_q;
    logic [WIDTH-1:0]   edge_raw;
    logic [WIDTH-1:0]   det;
    logic [WIDTH-1:0]   edge_q;
    logic [WIDTH-1:0]   edge_clr;
    logic [WIDTH-1:0]   mask_q;
    logic [COUNT_W-1:0] count_q;
    logic [ARM_W-1:0]   arm_cnt;
    logic               armed;
    logic               hit;
    logic               read_unused;

    assign read_unused = ^{read, writedata};

    status_pio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (sync_q)
    );

    // Disarm window covers the chain filling plus prev_q catching up,
    // so inputs already high at reset never look like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            arm_cnt <= ARM_W'(SYNC_STAGES + 1);
            prev_q  <= '0;
        end else begin
            if (arm_cnt != '0) begin
                arm_cnt <= arm_cnt - 1'b1;
            end
            prev_q <= sync_q;
        end
    end

    assign armed = (arm_cnt == '0);

    always_comb begin
        edge_raw = '0;
        case (EDGE_MODE)
            EDGE_RISE: edge_raw = sync_q & ~prev_q;
            EDGE_FALL: edge_raw = ~sync_q & prev_q;
            default:   edge_raw = sync_q ^ prev_q;
        endcase
        det = armed ? edge_raw : '0;
    end

    assign hit      = |det;
    assign edge_clr = (write && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    // New edges are ORed in after the clear, so a coincident set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_q  <= '0;
            count_q <= '0;
        end else begin
            edge_q <= (edge_q & ~edge_clr) | det;
            if (write && address == ADDR_COUNT) begin
                count_q <= COUNT_W'(hit);
            end else if (hit && count_q != '1) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

`ifdef STATUS_PIO_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= IRQ_RESET_MASK;
            irq    <= 1'b0;
        end else begin
            if (write && address == ADDR_MASK) begin
                mask_q <= writedata[WIDTH-1:0];
            end
            irq <= |(edge_q & mask_q);
        end
    end
`else
    assign mask_q = '0;
    assign irq    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_DATA: readdata <= 32'(sync_q);
                ADDR_MASK: readdata <= 32'(mask_q);
                ADDR_EDGE: readdata <= 32'(edge_q);
                default:   readdata <= 32'(count_q);
            endcase
        end
    end

endmodule

// File: tb/tb_status_pio_capture.sv
// Bench for status_pio_capture: directed test-plan steps plus a randomized phase, all cycles checked against a history-based model.
module tb_status_pio_capture;

    localparam int         W     = 8;
    localparam int         S     = 2;
    localparam int         MODE  = 0;
    localparam logic [W-1:0] RMASK = 8'h00;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] in_port;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    status_pio_capture #(
        .WIDTH          (W),
        .SYNC_STAGES    (S),
        .EDGE_MODE      (MODE),
        .IRQ_RESET_MASK (RMASK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    // Model state: what software should see, derived from the input history.
    logic [W-1:0]  m_sync, m_prev, m_edge, m_mask;
    logic [15:0]   m_count;
    logic [31:0]   m_rd;
    logic          m_irq;
    int            m_k;
    logic [W-1:0]  inq[$];

    function automatic logic [W-1:0] detect(input logic [W-1:0] cur, input logic [W-1:0] prv);
        case (MODE)
            0:       return cur & ~prv;
            1:       return ~cur & prv;
            default: return cur ^ prv;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [W-1:0] det;
        logic [W-1:0] clr;
        if (reset) begin
            m_rd = '0; m_irq = 1'b0; m_edge = '0; m_count = '0;
`ifdef STATUS_PIO_IRQ_EN
            m_mask = RMASK;
`else
            m_mask = '0;
`endif
            m_sync = '0; m_prev = '0; m_k = 0;
            inq.delete();
        end else begin
            case (address)
                2'd0:    m_rd = 32'(m_sync);
                2'd1:    m_rd = 32'(m_mask);
                2'd2:    m_rd = 32'(m_edge);
                default: m_rd = 32'(m_count);
            endcase
            m_irq = |(m_edge & m_mask);
            det = (m_k >= S + 1) ? detect(m_sync, m_prev) : '0;
            clr = (write && address == 2'd2) ? writedata[W-1:0] : '0;
            m_edge = (m_edge & ~clr) | det;
            if (write && address == 2'd3) m_count = (det != '0) ? 16'd1 : 16'd0;
            else if (det != '0 && m_count != 16'hFFFF) m_count = m_count + 16'd1;
`ifdef STATUS_PIO_IRQ_EN
            if (write && address == 2'd1) m_mask = writedata[W-1:0];
`endif
            inq.push_back(in_port);
            if (inq.size() > S) void'(inq.pop_front());
            m_prev = m_sync;
            m_sync = (m_k + 1 >= S) ? inq[0] : '0;
            m_k++;
        end
        @(posedge clk);
        @(negedge clk);
        chk("readdata_model", readdata, m_rd);
        chk("irq_model", {31'b0, irq}, {31'b0, m_irq});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; write = 1'b1; writedata = d;
        tick();
        write = 1'b0;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address = a;
        tick();
        chk(tag, readdata, exp);
    endtask

    initial begin
        int hold;
        reset = 1'b1; address = 2'd0; read = 1'b0; write = 1'b0;
        writedata = '0; in_port = 8'hFF;
        repeat (3) tick();
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);

        // Inputs high through reset must not capture.
        reset = 1'b0; read = 1'b1; address = 2'd2;
        repeat (10) tick();
        chk("edge_held_high", readdata, 32'h0);
        rd_chk(2'd0, 32'hFF, "data_held_high");
        chk("irq_idle", {31'b0, irq}, 32'h0);

        // Two-cycle pulse on bit 3.
        in_port = 8'h00;
        repeat (4) tick();
        address = 2'd2; in_port = 8'h08;
        tick(); tick();
        in_port = 8'h00;
        tick();
        chk("edge_t2", readdata, 32'h0);
        tick();
        chk("edge_t3", readdata, 32'h08);
        rd_chk(2'd3, 32'h1, "count_one");
        wr(2'd2, 32'h08);
        rd_chk(2'd2, 32'h0, "edge_w1c");

`ifdef STATUS_PIO_IRQ_EN
        wr(2'd1, 32'h08);
        rd_chk(2'd1, 32'h08, "mask_rw");
        in_port = 8'h08;
        tick(); tick();
        in_port = 8'h00;
        tick();
        chk("irq_early", {31'b0, irq}, 32'h0);
        tick(); tick();
        chk("irq_t4", {31'b0, irq}, 32'h1);
        wr(2'd2, 32'h08);
        chk("irq_hold", {31'b0, irq}, 32'h1);
        tick();
        chk("irq_drop", {31'b0, irq}, 32'h0);
`else
        wr(2'd1, 32'h08);
        rd_chk(2'd1, 32'h0, "mask_absent");
        in_port = 8'h08;
        tick(); tick();
        in_port = 8'h00;
        repeat (3) tick();
        chk("irq_tied", {31'b0, irq}, 32'h0);
        wr(2'd2, 32'h08);
`endif

        // Clear of bit 2 coincides with a fresh bit-2 edge.
        repeat (3) tick();
        in_port = 8'h04;
        tick(); tick();
        wr(2'd2, 32'h04);
        address = 2'd2;
        tick();
        chk("edge_set_wins", readdata, 32'h04);

        // Build EDGE=0x05, COUNT=0x20, then reset mid-stream.
        in_port = 8'h00;
        repeat (3) tick();
        wr(2'd2, 32'hFF);
        wr(2'd3, 32'h0);
        for (int i = 0; i < 32; i++) begin
            in_port = (i == 0) ? 8'h05 : 8'h01;
            tick(); tick();
            in_port = 8'h00;
            tick(); tick();
        end
        repeat (3) tick();
        rd_chk(2'd2, 32'h05, "edge_pre_reset");
        rd_chk(2'd3, 32'h20, "count_pre_reset");
        reset = 1'b1; address = 2'd0;
        tick();
        chk("rst_mid_readdata", readdata, 32'h0);
        reset = 1'b0; in_port = 8'h10; address = 2'd2;
        repeat (6) tick();
        chk("edge_disarmed", readdata, 32'h0);
        rd_chk(2'd3, 32'h0, "count_after_reset");
        rd_chk(2'd1, 32'(RMASK), "mask_after_reset");
        rd_chk(2'd0, 32'h10, "data_after_reset");
        chk("irq_after_reset", {31'b0, irq}, 32'h0);

        // Randomized traffic: inputs held >=2 cycles, random register accesses.
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                in_port = W'($urandom);
                hold = $urandom_range(2, 5);
            end
            hold--;
            reset     = ($urandom_range(0, 299) == 0);
            write     = ($urandom_range(0, 5) == 0);
            address   = 2'($urandom_range(0, 3));
            writedata = $urandom;
            read      = 1'($urandom);
            tick();
        end
        reset = 1'b0; write = 1'b0; read = 1'b1;

        // Saturate COUNT with an edge every cycle, then clear it on an edge.
        wr(2'd3, 32'h0);
        address = 2'd3;
        for (int i = 0; i < 66000; i++) begin
            in_port = (i % 2 == 1) ? 8'h02 : 8'h01;
            tick();
        end
        chk("count_saturated", readdata, 32'h0000FFFF);
        in_port = 8'h01;
        wr(2'd3, 32'h0);
        in_port = 8'h02;
        address = 2'd3;
        tick();
        chk("count_clear_edge", readdata, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
